// File: rtl/button_debounce.sv
// Synchronises and debounces a bouncy push-button; emits press/release/long-press strobes.
// Latency SYNC_STAGES+DEBOUNCE_CYCLES cycles raw edge to btn_level; no backpressure, strobes are fire-and-forget.
module button_debounce #(
    parameter int SYNC_STAGES       = 2,
    parameter int DEBOUNCE_CYCLES   = 16,
    parameter int LONG_PRESS_CYCLES = 256,
    parameter int CNT_W             = 9
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_press,
    output logic busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESS_Q = 2'd1,
        HELD    = 2'd2,
        REL_Q   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_MAX = CNT_W'(LONG_PRESS_CYCLES);
    localparam logic [CNT_W-1:0] LONG_PRE = CNT_W'(LONG_PRESS_CYCLES - 2);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_btn_sync;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [CNT_W-1:0]       r_deb_cnt;
    logic [CNT_W-1:0]       w_deb_nxt;
    logic [CNT_W-1:0]       r_hold_cnt;
    logic [CNT_W-1:0]       w_hold_nxt;
    logic                   w_press_nxt;
    logic                   w_release_nxt;
    logic                   w_long_nxt;
    logic                   w_level_nxt;
    logic                   w_busy_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], btn_raw};
        end
    end

    assign w_btn_sync = r_sync[SYNC_STAGES-1];

    // State, counters and every output are registered together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_deb_cnt     <= '0;
            r_hold_cnt    <= '0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_press    <= 1'b0;
            busy          <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_deb_cnt     <= w_deb_nxt;
            r_hold_cnt    <= w_hold_nxt;
            btn_level     <= w_level_nxt;
            press_pulse   <= w_press_nxt;
            release_pulse <= w_release_nxt;
            long_press    <= w_long_nxt;
            busy          <= w_busy_nxt;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_deb_nxt     = r_deb_cnt;
        w_hold_nxt    = r_hold_cnt;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        w_long_nxt    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_btn_sync) begin
                    w_next_state = PRESS_Q;
                    w_deb_nxt    = CNT_ONE;
                end
            end
            PRESS_Q: begin
                if (!w_btn_sync) begin
                    w_next_state = IDLE;
                    w_deb_nxt    = '0;
                end else if (r_deb_cnt == DEB_LAST) begin
                    w_next_state = HELD;
                    w_deb_nxt    = '0;
                    w_hold_nxt   = '0;
                    w_press_nxt  = 1'b1;
                end else begin
                    w_deb_nxt = r_deb_cnt + CNT_ONE;
                end
            end
            HELD: begin
                // Saturation keeps hold_cnt monotonic, so the strobe below fires once per press.
                if (r_hold_cnt != LONG_MAX) begin
                    w_hold_nxt = r_hold_cnt + CNT_ONE;
                end
                w_long_nxt = (r_hold_cnt == LONG_PRE);
                if (!w_btn_sync) begin
                    w_next_state = REL_Q;
                    w_deb_nxt    = CNT_ONE;
                end
            end
            REL_Q: begin
                if (w_btn_sync) begin
                    w_next_state = HELD;
                    w_deb_nxt    = '0;
                end else if (r_deb_cnt == DEB_LAST) begin
                    w_next_state  = IDLE;
                    w_deb_nxt     = '0;
                    w_hold_nxt    = '0;
                    w_release_nxt = 1'b1;
                end else begin
                    w_deb_nxt = r_deb_cnt + CNT_ONE;
                end
            end
            default: begin
                w_next_state = IDLE;
                w_deb_nxt    = '0;
                w_hold_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        w_level_nxt = (w_next_state == HELD) || (w_next_state == REL_Q);
        w_busy_nxt  = (w_next_state == PRESS_Q) || (w_next_state == REL_Q);
    end

endmodule

// File: tb/tb_button_debounce.sv
// Scenario bench for button_debounce against a run-length reference model.
// Inputs change on the falling edge; outputs are sampled on the falling edge after each rising edge.
module tb_button_debounce;

    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int LONG = 20;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic btn_raw = 1'b0;
    logic btn_level, press_pulse, release_pulse, long_press, busy;

    int checks = 0;
    int errors = 0;

    button_debounce #(
        .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .LONG_PRESS_CYCLES(LONG), .CNT_W(9)
    ) dut (
        .clk(clk), .rst(rst), .btn_raw(btn_raw),
        .btn_level(btn_level), .press_pulse(press_pulse), .release_pulse(release_pulse),
        .long_press(long_press), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference: a change is accepted after DEB consecutive synchronised samples that
    // differ from the current level; long_press marks the (LONG-1)th settled held cycle.
    logic m_s0, m_s1, m_level, m_press, m_rel, m_long;
    int   m_run, m_hold;
    logic m_busy;
    assign m_busy = (m_run != 0);

    always @(posedge clk or negedge rst) begin : ref_model
        logic s, lvl, p, r, l;
        int   run, hold;
        if (!rst) begin
            m_s0 <= 1'b0; m_s1 <= 1'b0; m_run <= 0; m_hold <= 0;
            m_level <= 1'b0; m_press <= 1'b0; m_rel <= 1'b0; m_long <= 1'b0;
        end else begin
            s = m_s1; lvl = m_level; run = m_run; hold = m_hold;
            p = 1'b0; r = 1'b0; l = 1'b0;
            if (lvl && run == 0 && hold < LONG) begin
                hold = hold + 1;
                if (hold == LONG - 1) l = 1'b1;
            end
            if (s != lvl) begin
                run = run + 1;
                if (run == DEB) begin
                    lvl = s; run = 0; hold = 0; p = s; r = !s;
                end
            end else begin
                run = 0;
            end
            m_s1 <= m_s0; m_s0 <= btn_raw;
            m_run <= run; m_hold <= hold; m_level <= lvl;
            m_press <= p; m_rel <= r; m_long <= l;
        end
    end

    logic [4:0] dut_v, mdl_v;
    assign dut_v = {btn_level, press_pulse, release_pulse, long_press, busy};
    assign mdl_v = {m_level, m_press, m_rel, m_long, m_busy};

    task automatic tick(input logic raw);
        btn_raw = raw;
        @(negedge clk);
    endtask

    task automatic do_reset(input logic raw);
        rst = 1'b0;
        btn_raw = raw;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset;
        int p_at, p_cnt;
        do_reset(1'b1);
        checks++;
        if (dut_v !== 5'b0) begin
            errors++; $display("FAIL reset_outputs got %b want 00000", dut_v);
        end
        p_at = -1; p_cnt = 0;
        for (int i = 1; i <= 10; i++) begin
            tick(1'b1);
            if (press_pulse) begin p_cnt++; if (p_at < 0) p_at = i; end
            checks++;
            if (dut_v !== mdl_v) begin
                errors++; $display("FAIL reset_model t=%0d got %b want %b", i, dut_v, mdl_v);
            end
        end
        checks++;
        if (p_at !== 6 || p_cnt !== 1) begin
            errors++; $display("FAIL reset_first_press at=%0d n=%0d want at=6 n=1", p_at, p_cnt);
        end
    endtask

    task automatic test_glitch;
        int busy_n, pulses, lvl_hi;
        do_reset(1'b0);
        busy_n = 0; pulses = 0; lvl_hi = 0;
        for (int i = 0; i < 16; i++) begin
            tick((i >= 2 && i < 5) ? 1'b1 : 1'b0);
            busy_n += busy;
            pulses += press_pulse + release_pulse + long_press;
            lvl_hi += btn_level;
            checks++;
            if (dut_v !== mdl_v) begin
                errors++; $display("FAIL glitch_model t=%0d got %b want %b", i, dut_v, mdl_v);
            end
        end
        checks++;
        if (busy_n !== 3 || pulses !== 0 || lvl_hi !== 0) begin
            errors++;
            $display("FAIL glitch_reject busy=%0d pulses=%0d lvl=%0d want 3 0 0", busy_n, pulses, lvl_hi);
        end
    endtask

    task automatic test_long_press;
        int p_at, l_at, l_cnt, lvl_lo;
        do_reset(1'b0);
        tick(1'b0); tick(1'b0);
        p_at = -1; l_at = -1; l_cnt = 0; lvl_lo = 0;
        for (int i = 1; i <= 40; i++) begin
            tick(1'b1);
            if (press_pulse) p_at = i;
            if (long_press) begin l_cnt++; l_at = i; end
            if (i >= 6 && !btn_level) lvl_lo++;
            checks++;
            if (dut_v !== mdl_v) begin
                errors++; $display("FAIL long_model t=%0d got %b want %b", i, dut_v, mdl_v);
            end
        end
        checks++;
        if (p_at !== 6 || l_cnt !== 1 || l_at !== 25 || lvl_lo !== 0) begin
            errors++;
            $display("FAIL long_timing press=%0d long=%0d n=%0d lvl_lo=%0d want 6 25 1 0", p_at, l_at, l_cnt, lvl_lo);
        end
    endtask

    task automatic test_short_release;
        int r_at, l_cnt;
        do_reset(1'b0);
        l_cnt = 0; r_at = -1;
        for (int i = 1; i <= 10; i++) begin
            tick(1'b1);
            l_cnt += long_press;
        end
        for (int j = 1; j <= 30; j++) begin
            tick(1'b0);
            l_cnt += long_press;
            if (release_pulse) r_at = j;
            checks++;
            if (dut_v !== mdl_v) begin
                errors++; $display("FAIL short_model t=%0d got %b want %b", j, dut_v, mdl_v);
            end
        end
        checks++;
        if (r_at !== 6 || l_cnt !== 0 || btn_level !== 1'b0) begin
            errors++;
            $display("FAIL short_release rel=%0d long=%0d lvl=%b want 6 0 0", r_at, l_cnt, btn_level);
        end
    endtask

    task automatic test_bounce_held;
        int r_cnt, l_cnt, lvl_lo;
        do_reset(1'b0);
        r_cnt = 0; l_cnt = 0; lvl_lo = 0;
        for (int i = 1; i <= 57; i++) begin
            tick((i > 15 && i <= 17) ? 1'b0 : 1'b1);
            r_cnt += release_pulse;
            l_cnt += long_press;
            if (i >= 6 && !btn_level) lvl_lo++;
            checks++;
            if (dut_v !== mdl_v) begin
                errors++; $display("FAIL bounce_model t=%0d got %b want %b", i, dut_v, mdl_v);
            end
        end
        checks++;
        if (r_cnt !== 0 || l_cnt !== 1 || lvl_lo !== 0) begin
            errors++;
            $display("FAIL bounce_held rel=%0d long=%0d lvl_lo=%0d want 0 1 0", r_cnt, l_cnt, lvl_lo);
        end
    endtask

    task automatic test_reset_mid;
        int p_at;
        do_reset(1'b0);
        for (int i = 0; i < 12; i++) tick(1'b1);
        checks++;
        if (btn_level !== 1'b1) begin
            errors++; $display("FAIL mid_pre_level got %b want 1", btn_level);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (btn_level !== 1'b0 || release_pulse !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_async_clear lvl=%b rel=%b busy=%b want 0 0 0", btn_level, release_pulse, busy);
        end
        @(negedge clk);
        rst = 1'b1;
        p_at = -1;
        for (int i = 1; i <= 10; i++) begin
            tick(1'b1);
            if (press_pulse && p_at < 0) p_at = i;
            checks++;
            if (release_pulse !== 1'b0) begin
                errors++; $display("FAIL mid_no_release t=%0d got %b want 0", i, release_pulse);
            end
        end
        checks++;
        if (p_at !== 6) begin
            errors++; $display("FAIL mid_repress at=%0d want 6", p_at);
        end
    endtask

    task automatic test_random;
        logic v;
        int   len, excl_bad;
        do_reset(1'b0);
        v = 1'b0; excl_bad = 0;
        for (int run = 0; run < 80; run++) begin
            v = ~v;
            len = ($urandom_range(0, 4) == 0) ? $urandom_range(20, 35) : $urandom_range(1, 8);
            for (int k = 0; k < len; k++) begin
                tick(v);
                if (int'(press_pulse) + int'(release_pulse) + int'(long_press) > 1) excl_bad++;
                checks++;
                if (dut_v !== mdl_v) begin
                    errors++; $display("FAIL random_model run=%0d k=%0d got %b want %b", run, k, dut_v, mdl_v);
                end
            end
        end
        checks++;
        if (excl_bad !== 0) begin
            errors++; $display("FAIL strobe_exclusive count=%0d want 0", excl_bad);
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_long_press();
        test_short_release();
        test_bounce_held();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
